// File: rtl/anspwm_dec.sv
// Averaging decimator that rebuilds a 16.16 value from the quantized 16-bit sample stream.
// Block averaging by default; define ANSPWM_DEC_SLIDING_EN for a moving average over the last N samples.
module anspwm_dec #(
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [15:0]       val_in,
    output logic              out_valid,
    output logic [31:0]       avg_out,
    output logic [LOG2_N:0]   fill_out
);
    localparam int N  = 1 << LOG2_N;
    localparam int AW = 16 + LOG2_N;
    localparam int SH = 16 - LOG2_N;

    logic          accept;
    logic [AW-1:0] acc_reg;
    logic [AW-1:0] sum;

    assign accept = in_valid && !clr;

    // Appending SH zero bits to an N-sample sum is exactly sum/N in 16.16.
    function automatic logic [31:0] scale(input logic [AW-1:0] s);
        return 32'(s) << SH;
    endfunction

`ifdef ANSPWM_DEC_SLIDING_EN
    typedef enum logic {FILL, RUN} state_t;

    localparam logic [LOG2_N:0]   FILL_LAST = (LOG2_N+1)'(N - 1);
    localparam logic [LOG2_N:0]   FILL_ONE  = (LOG2_N+1)'(1);
    localparam logic [LOG2_N-1:0] WP_ONE    = LOG2_N'(1);

    state_t            state_reg;
    logic [15:0]       sample_mem [N];
    logic [15:0]       old_reg;
    logic [LOG2_N-1:0] wp_reg;
    logic [LOG2_N-1:0] wp_next;
    logic [LOG2_N:0]   fill_reg;

    assign wp_next  = clr ? '0 : (accept ? wp_reg + WP_ONE : wp_reg);
    assign sum      = acc_reg + AW'(val_in) - ((state_reg == RUN) ? AW'(old_reg) : '0);
    assign fill_out = fill_reg;

    // Registered read one step ahead: old_reg always holds the entry at wp_reg,
    // which is never the address being written in the same cycle since N >= 2.
    always_ff @(posedge clk) begin
        if (accept)
            sample_mem[wp_reg] <= val_in;
        old_reg <= sample_mem[wp_next];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= FILL;
            acc_reg   <= '0;
            wp_reg    <= '0;
            fill_reg  <= '0;
            out_valid <= 1'b0;
            avg_out   <= '0;
        end else if (clr) begin
            state_reg <= FILL;
            acc_reg   <= '0;
            wp_reg    <= '0;
            fill_reg  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                acc_reg <= sum;
                wp_reg  <= wp_next;
                if (state_reg == FILL) begin
                    fill_reg <= fill_reg + FILL_ONE;
                    if (fill_reg == FILL_LAST) begin
                        state_reg <= RUN;
                        out_valid <= 1'b1;
                        avg_out   <= scale(sum);
                    end
                end else begin
                    out_valid <= 1'b1;
                    avg_out   <= scale(sum);
                end
            end
        end
    end
`else
    localparam logic [LOG2_N-1:0] CNT_ONE = LOG2_N'(1);

    logic [LOG2_N-1:0] cnt_reg;

    assign sum      = acc_reg + AW'(val_in);
    assign fill_out = {1'b0, cnt_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            out_valid <= 1'b0;
            avg_out   <= '0;
        end else if (clr) begin
            acc_reg   <= '0;
            cnt_reg   <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                if (&cnt_reg) begin
                    acc_reg   <= '0;
                    cnt_reg   <= '0;
                    out_valid <= 1'b1;
                    avg_out   <= scale(sum);
                end else begin
                    acc_reg <= sum;
                    cnt_reg <= cnt_reg + CNT_ONE;
                end
            end
        end
    end
`endif
endmodule

// File: doc/anspwm_dec.md
# anspwm_dec

Reconstruction decimator for the noise-shaped quantizer output. It takes the 16-bit quantized sample stream (integer part of a 16.16 target with error feedback) and averages it over 2^LOG2_N samples to recover the high-resolution value. The result is a 32-bit 16.16 value. It sits on the receive/monitor side of the PWM path and is used both in-system and in loopback benches against the quantizer.

## Interface
- LOG2_N, 4, log2 of averaging window length N; legal range 1..16
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous restart of the current window; active-high
- in_valid  in  1  val_in is a sample this cycle
- val_in  in  16  quantized sample, unsigned integer part
- out_valid  out  1  one-cycle pulse: avg_out updated this cycle
- avg_out  out  32  reconstructed average, unsigned 16.16
- fill_out  out  LOG2_N+1  samples accumulated in current window, 0..N

## Operation
- Accumulator `acc` is 16+LOG2_N bits wide. The maximum N·0xFFFF fits, so it never overflows.
- Output scaling is avg_out = {acc_final, (16-LOG2_N) zero bits}. This equals sum/N in 16.16 and involves no rounding.
- A sample is accepted only when in_valid=1 and clr=0.
- Block mode (default):
  - Counter `cnt` runs 0..N-1.
  - On accept with cnt<N-1: acc += val_in and cnt++.
  - On accept with cnt==N-1: avg_out <= scaled(acc+val_in), out_valid <= 1, acc <= 0, cnt <= 0.
  - fill_out = cnt.
- clr:
  - acc, cnt, state and fill_out go to 0, and out_valid goes to 0.
  - avg_out holds its last value.
  - clr together with in_valid: clr wins and the sample is dropped.
- in_valid gaps of any length are allowed. State holds and no timeout applies.
- Reset values: out_valid=0, avg_out=0, fill_out=0, acc=0, cnt=0, state FILL.
- Reset asserted mid-window discards the partial window immediately, asynchronously.

## Timing
- All outputs are registered.
- Latency: out_valid and avg_out change on the clock edge that accepts the Nth sample of a window, and are visible the following cycle.
- out_valid is high for exactly one cycle per produced result. No backpressure; the consumer must sample it on the pulse.
- Back-to-back in_valid at full rate is supported. Throughput is 1 sample/cycle.
- Block mode: one result per N accepted samples.

## Configuration
- Macro: ANSPWM_DEC_SLIDING_EN.
- Defined: sliding (moving-average) mode replaces block mode.
  - Adds an N-entry circular sample buffer with write pointer `wp`.
  - Two-state FSM: FILL and RUN.
  - FILL: each accept does acc += val_in, buf[wp] <= val_in, wp++ and fill_out++. On the Nth accept, go to RUN and pulse out_valid with the scaled sum.
  - RUN: each accept does acc <= acc + val_in - buf[wp], buf[wp] <= val_in, wp++ (wraps at N), and pulses out_valid every accept. fill_out stays N.
  - clr or rst returns to FILL with wp=0 and acc=0. Buffer contents need not be cleared because FILL never reads them.
- Undefined: block mode only. No sample buffer is instantiated.

## Test plan
- Reset/idle: assert rst mid-window with 7 samples taken, release, then send 16×0x0003 (LOG2_N=4). Expect all outputs 0 during reset and a single out_valid with avg_out=0x0003_0000.
- Constant in: 16×0x8000 at full rate. Expect out_valid one cycle after the 16th accept, avg_out=0x8000_0000, then no further pulse until 16 more samples.
- Loopback: quantizer with tgt_in=0x0001_4000 drives val_in, giving pattern 1,1,1,2 repeated. Expect every block avg_out=0x0001_4000. With SLIDING_EN, every pulse after fill also gives 0x0001_4000.
- Extremes/gaps: 16×0xFFFF with random in_valid gaps of 0..5 cycles. Expect avg_out=0xFFFF_0000 with no wrap, and fill_out tracking the accepted count.
- clr: after 9 samples of 0x0010, assert clr together with in_valid, then send 16×0x0020. Expect the clr-cycle sample dropped, fill_out=0, avg_out held at its prior value, then a result of 0x0020_0000.
- SLIDING_EN step: 16×0x0000 then 0x0010 repeated. Expect the first pulse at 0, then avg_out rising by 0x0001_0000 per sample, reaching 0x0010_0000 after 16 more samples, with out_valid every accept.
